// File: rtl/instruction_fetch_unit.sv
// PC/fetch stage: drives a 1-cycle synchronous imem, queues returns in a prefetch FIFO, emits valid/ready {instr, pc}.
// Fetch-to-output latency 2 cycles; issue is throttled so FIFO + in-flight read never exceed FIFO_DEPTH.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic        imem_rd,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;
  logic          req_valid;
  logic [31:0]   fifo_instr [FIFO_DEPTH];
  logic [31:0]   fifo_pc    [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW:0]   demand;
  logic          pop;
  logic          push;
  logic          issue;

  assign pop    = out_valid & out_ready;
  assign push   = req_valid & !redirect_valid;
  // Slots already claimed (queued + in flight), crediting this cycle's pop so depth 2 streams at full rate.
  assign demand = (CW+1)'(count) + (CW+1)'(req_valid) - (CW+1)'(pop);
  assign issue  = !rst & !redirect_valid & (demand < DEPTH_C);

  assign imem_addr = fetch_pc;
  assign imem_rd   = issue;
  assign out_valid = (count != '0);
  assign out_instr = fifo_instr[rd_ptr];
  assign out_pc    = fifo_pc[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc  <= RESET_PC;
      req_pc    <= '0;
      req_valid <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
      end
    end else if (redirect_valid) begin
      // Flush queue and drop the read returning this cycle; a same-cycle pop has already been taken.
      fetch_pc  <= redirect_pc & 32'hFFFF_FFFC;
      req_valid <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
    end else begin
      req_valid <= issue;
      if (issue) begin
        req_pc   <= fetch_pc;
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (push) begin
        fifo_instr[wr_ptr] <= imem_data;
        fifo_pc[wr_ptr]    <= req_pc;
        wr_ptr             <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // The issue rule reserves a slot for every read, so a write into a full FIFO means the throttle is broken.
  assert property (@(posedge clk) disable iff (rst) !(push && !pop && count == CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: timestamped-queue reference model checked every cycle, plus literal spot checks.
module tb_instruction_fetch_unit;

  localparam logic [31:0] K     = 32'hC0DE_0000;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr, imem_data = '0, out_instr, out_pc;
  logic        imem_rd, out_valid;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_ready = 1'b1;

  logic [31:0] imem_addr2, imem_data2 = '0, out_instr2, out_pc2;
  logic        imem_rd2, out_valid2;
  logic        redirect_valid2 = 1'b0;
  logic [31:0] redirect_pc2 = '0;
  logic        out_ready2 = 1'b1;

  int total = 0;
  int bad   = 0;

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut2 (
    .clk(clk), .rst(rst), .imem_addr(imem_addr2), .imem_rd(imem_rd2), .imem_data(imem_data2),
    .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2), .out_valid(out_valid2),
    .out_ready(out_ready2), .out_instr(out_instr2), .out_pc(out_pc2)
  );

  always #5 clk = ~clk;

  // Instruction memories: one-cycle synchronous read, word = addr ^ K.
  always @(posedge clk) if (imem_rd)  imem_data  <= imem_addr  ^ K;
  always @(posedge clk) if (imem_rd2) imem_data2 <= imem_addr2 ^ K;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each fetched PC carries its issue cycle; it is presentable two cycles later.
  logic [31:0] q_pc[$];
  int          q_t[$];
  logic [31:0] m_fetch;
  int          cyc;
  logic [31:0] acc_log[$];
  logic [31:0] shown_log[$];

  always @(negedge clk) begin : model
    bit ev, ep, ei;
    if (rst) begin
      q_pc.delete(); q_t.delete(); acc_log.delete(); shown_log.delete();
      m_fetch = 32'h0;
      cyc     = 0;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_imem_rd",   32'(imem_rd),   32'd0);
      chk("rst_imem_addr", imem_addr,      32'h0);
    end else begin
      ev = 1'b0;
      if (q_pc.size() > 0) ev = (cyc >= q_t[0] + 2);
      ep = ev && out_ready;
      ei = !redirect_valid && ((q_pc.size() - (ep ? 1 : 0)) < DEPTH);
      chk("m_imem_rd",   32'(imem_rd),   32'(ei));
      chk("m_imem_addr", imem_addr,      m_fetch);
      chk("m_out_valid", 32'(out_valid), 32'(ev));
      if (ev) begin
        chk("m_out_pc",    out_pc,    q_pc[0]);
        chk("m_out_instr", out_instr, q_pc[0] ^ K);
      end
      if (out_valid) shown_log.push_back(out_pc);
      if (out_valid && out_ready) acc_log.push_back(out_pc);
      if (ep) begin
        void'(q_pc.pop_front());
        void'(q_t.pop_front());
      end
      if (redirect_valid) begin
        q_pc.delete(); q_t.delete();
        m_fetch = {redirect_pc[31:2], 2'b00};
      end else if (ei) begin
        q_pc.push_back(m_fetch);
        q_t.push_back(cyc);
        m_fetch = m_fetch + 32'd4;
      end
      cyc++;
    end
  end

  task automatic nc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n10, n14;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;                                   // cycle 0
    @(negedge clk);
    chk("t1_rd_c0",    32'(imem_rd),   32'd1);
    chk("t1_addr_c0",  imem_addr,      32'h0);
    chk("t1_valid_c0", 32'(out_valid), 32'd0);
    chk("t4_addr2_c0", imem_addr2,     32'hFFFF_FFF8);
    nc(); @(negedge clk);                            // cycle 1
    chk("t4_addr2_c1", imem_addr2,     32'hFFFF_FFFC);
    chk("t1_valid_c1", 32'(out_valid), 32'd0);
    nc(); @(negedge clk);                            // cycle 2
    chk("t1_valid_c2", 32'(out_valid), 32'd1);
    chk("t1_pc_c2",    out_pc,         32'h0);
    chk("t1_instr_c2", out_instr,      32'hC0DE_0000);
    chk("t4_addr2_c2", imem_addr2,     32'h0);
    chk("t4_pc2_c2",   out_pc2,        32'hFFFF_FFF8);
    nc(); @(negedge clk);                            // cycle 3
    chk("t1_pc_c3",    out_pc,         32'h4);
    nc(); @(negedge clk);                            // cycle 4
    chk("t4_pc2_c4",    out_pc2,       32'h0);
    chk("t4_instr2_c4", out_instr2,    32'hC0DE_0000);

    nc(); out_ready = 1'b0;                          // cycle 5: stall 6 cycles
    nc();
    nc(); @(negedge clk);                            // cycle 7
    chk("t2_rd_stall",    32'(imem_rd),   32'd0);
    chk("t2_valid_stall", 32'(out_valid), 32'd1);
    chk("t2_pc_stall",    out_pc,         32'hC);
    chk("t2_addr_stall",  imem_addr,      32'h14);
    repeat (4) nc();
    out_ready = 1'b1;                                // cycle 11
    nc();
    nc(); @(negedge clk);                            // cycle 13
    chk("t2_pc_resume", out_pc, 32'h14);

    nc();                                            // cycle 14: redirect with read in flight
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    nc();                                            // cycle 15
    redirect_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("t3_valid_r1", 32'(out_valid), 32'd0);
    chk("t3_addr_r1",  imem_addr,      32'h100);
    chk("t3_rd_r1",    32'(imem_rd),   32'd1);
    nc(); @(negedge clk);                            // cycle 16
    chk("t3_valid_r2", 32'(out_valid), 32'd0);
    nc(); @(negedge clk);                            // cycle 17
    chk("t3_valid_r3", 32'(out_valid), 32'd1);
    chk("t3_pc_r3",    out_pc,         32'h100);
    chk("t3_instr_r3", out_instr,      32'hC0DE_0100);

    nc(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0203;   // cycle 18
    nc(); redirect_valid = 1'b0;                     // cycle 19
    @(negedge clk);
    chk("t4_addr_align", imem_addr, 32'h200);
    nc();
    nc(); @(negedge clk);                            // cycle 21
    chk("t4_pc_align", out_pc, 32'h200);
    nc(); nc();

    @(posedge clk); #3 rst = 1'b1;                   // asynchronous mid-cycle reset
    #1;
    chk("t6_valid_async",  32'(out_valid),  32'd0);
    chk("t6_addr_async",   imem_addr,       32'h0);
    chk("t6_valid2_async", 32'(out_valid2), 32'd0);
    chk("t6_addr2_async",  imem_addr2,      32'hFFFF_FFF8);
    @(posedge clk); #1 rst = 1'b0;                   // cycle 0 again
    @(negedge clk);
    chk("t6_rd_c0",   32'(imem_rd), 32'd1);
    chk("t6_addr_c0", imem_addr,    32'h0);
    nc(); nc(); @(negedge clk);                      // cycle 2
    chk("t6_valid_c2", 32'(out_valid), 32'd1);
    chk("t6_pc_c2",    out_pc,         32'h0);
    repeat (4) nc();                                 // cycle 6: redirect while popping 0x10
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0400;
    @(negedge clk);
    chk("t5_pc_pop", out_pc, 32'h10);
    nc(); redirect_valid = 1'b0;                     // cycle 7
    nc(); nc(); @(negedge clk);                      // cycle 9
    chk("t5_pc_target", out_pc, 32'h400);
    repeat (3) nc();
    @(negedge clk);

    n10 = 0; n14 = 0;
    foreach (acc_log[i])   if (acc_log[i] == 32'h10) n10++;
    foreach (shown_log[i]) if (shown_log[i] == 32'h14) n14++;
    chk("t5_pc10_once",   32'(n10), 32'd1);
    chk("t5_pc14_absent", 32'(n14), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
